circuit_1_hlsm: RTL and testbench

//   Scheduled, resource-shared counterpart of the circuit_1 datapath: computes the same results
//   (z, x) from a, b, c, but runs as an FSMD with a Start/Done handshake.
//   One shared adder/subtractor, one multiplier and one comparator are sequenced over four states.

---
 rtl/circuit_1_hlsm_pkg.sv | 24 ++
 rtl/circuit_1_hlsm_dp.sv | 62 ++++++
 rtl/circuit_1_hlsm.sv | 72 +++++++
 tb/tb_circuit_1_hlsm.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/circuit_1_hlsm_pkg.sv
// Shared definitions for circuit_1_hlsm: state encodings, default width and the
// controller-to-datapath control bundle.
package circuit_1_hlsm_pkg;

    localparam int DW_DEFAULT = 8;

    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S_ADD1  = 3'd1;
    localparam logic [2:0] S_ADD2  = 3'd2;
    localparam logic [2:0] S_MUL   = 3'd3;
    localparam logic [2:0] S_SUB   = 3'd4;
    localparam logic [2:0] S_FINAL = 3'd5;

    typedef struct packed {
        logic ld_op;     // latch a, b, c
        logic sel_op;    // shared adder second operand: 0 = b_r, 1 = c_r
        logic sub_mode;  // shared unit computes f - d instead of an add
        logic ld_d;
        logic ld_e;
        logic ld_f;      // also loads the comparator result
        logic ld_out;    // loads z and x
    } dp_ctrl_t;

endpackage

// File: rtl/circuit_1_hlsm_dp.sv
// Datapath for circuit_1_hlsm: operand/result registers around one shared
// add/sub unit, one multiplier, one comparator and the z output mux.
module circuit_1_hlsm_dp
    import circuit_1_hlsm_pkg::*;
#(
    parameter int DATAWIDTH = DW_DEFAULT
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  dp_ctrl_t                 ctrl,
    input  logic [DATAWIDTH-1:0]     a,
    input  logic [DATAWIDTH-1:0]     b,
    input  logic [DATAWIDTH-1:0]     c,
    output logic [DATAWIDTH-1:0]     z,
    output logic [2*DATAWIDTH-1:0]   x
);

    logic [DATAWIDTH-1:0]   a_r, b_r, c_r, d, e;
    logic [2*DATAWIDTH-1:0] f;
    logic                   gt;

    logic [2*DATAWIDTH-1:0] as_in0, as_in1, as_res;

    // The shared unit is 2*DW wide so the subtract covers x; adds keep only the low DW bits.
    always_comb begin
        as_in0 = ctrl.sub_mode ? f : {{DATAWIDTH{1'b0}}, a_r};
        as_in1 = ctrl.sub_mode ? {{DATAWIDTH{1'b0}}, d}
                               : {{DATAWIDTH{1'b0}}, (ctrl.sel_op ? c_r : b_r)};
        as_res = ctrl.sub_mode ? (as_in0 - as_in1) : (as_in0 + as_in1);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            a_r <= '0;
            b_r <= '0;
            c_r <= '0;
            d   <= '0;
            e   <= '0;
            f   <= '0;
            gt  <= 1'b0;
            z   <= '0;
            x   <= '0;
        end else begin
            if (ctrl.ld_op) begin
                a_r <= a;
                b_r <= b;
                c_r <= c;
            end
            if (ctrl.ld_d) d <= as_res[DATAWIDTH-1:0];
            if (ctrl.ld_e) e <= as_res[DATAWIDTH-1:0];
            if (ctrl.ld_f) begin
                f  <= a_r * c_r;
                gt <= (d > e);
            end
            if (ctrl.ld_out) begin
                x <= as_res;
                z <= gt ? e : d;
            end
        end
    end

endmodule

// File: rtl/circuit_1_hlsm.sv
// Scheduled FSMD form of circuit_1: z = min-style select of d/e, x = a*c - d,
// computed over a fixed six-state schedule with a Start/Done handshake.
module circuit_1_hlsm
    import circuit_1_hlsm_pkg::*;
#(
    parameter int DATAWIDTH = DW_DEFAULT
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Start,
    input  logic [DATAWIDTH-1:0]     a,
    input  logic [DATAWIDTH-1:0]     b,
    input  logic [DATAWIDTH-1:0]     c,
    output logic                     Done,
    output logic [DATAWIDTH-1:0]     z,
    output logic [2*DATAWIDTH-1:0]   x,
    output logic [2:0]               dbg_state
);

    // Handshake: Start is a request sampled only in S_WAIT (no queuing, ignored elsewhere);
    // Done is a one-cycle registered pulse, after which z/x hold until the next run's S_SUB.
    logic [2:0] state, state_nxt;
    dp_ctrl_t   ctrl;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_WAIT:  state_nxt = Start ? S_ADD1 : S_WAIT;
            S_ADD1:  state_nxt = S_ADD2;
            S_ADD2:  state_nxt = S_MUL;
            S_MUL:   state_nxt = S_SUB;
            S_SUB:   state_nxt = S_FINAL;
            S_FINAL: state_nxt = S_WAIT;
            default: state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        ctrl          = '0;
        ctrl.ld_op    = (state == S_WAIT) && Start;
        ctrl.sel_op   = (state == S_ADD2);
        ctrl.sub_mode = (state == S_SUB);
        ctrl.ld_d     = (state == S_ADD1);
        ctrl.ld_e     = (state == S_ADD2);
        ctrl.ld_f     = (state == S_MUL);
        ctrl.ld_out   = (state == S_SUB);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= S_WAIT;
            Done  <= 1'b0;
        end else begin
            state <= state_nxt;
            Done  <= (state == S_FINAL);
        end
    end

    assign dbg_state = state;

    circuit_1_hlsm_dp #(.DATAWIDTH(DATAWIDTH)) u_dp (
        .Clk  (Clk),
        .Rst  (Rst),
        .ctrl (ctrl),
        .a    (a),
        .b    (b),
        .c    (c),
        .z    (z),
        .x    (x)
    );

endmodule

// File: tb/tb_circuit_1_hlsm.sv
// Directed scoreboard bench for circuit_1_hlsm: stimulus pushes {done cycle, z, x},
// a negedge monitor pops and compares on every Done pulse.
module tb_circuit_1_hlsm;
    import circuit_1_hlsm_pkg::*;

    localparam int DW = 8;
    localparam int W  = 16 + DW + 2*DW;

    logic          Clk;
    logic          Rst;
    logic          Start;
    logic [DW-1:0] a, b, c;
    logic          Done;
    logic [DW-1:0] z;
    logic [2*DW-1:0] x;
    logic [2:0]    dbg_state;

    logic [W-1:0]  exp_q[$];
    int            cyc;
    int            n_vec;
    int            n_fail;

    circuit_1_hlsm #(.DATAWIDTH(DW)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .a         (a),
        .b         (b),
        .c         (c),
        .Done      (Done),
        .z         (z),
        .x         (x),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // scoreboard monitor
    always @(negedge Clk) begin
        if (Done) begin
            n_vec = n_vec + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_done: got Done=1 z=%0d x=%0d, required no Done", z, x);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (cyc != int'(e[W-1:3*DW]) || z != e[3*DW-1:2*DW] || x != e[2*DW-1:0]) begin
                    n_fail = n_fail + 1;
                    $display("FAIL result: got cyc=%0d z=%0d x=%0d, required cyc=%0d z=%0d x=%0d",
                             cyc, z, x, e[W-1:3*DW], e[3*DW-1:2*DW], e[2*DW-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec = n_vec + 1;
        if (got !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push_exp(input int done_cyc, input logic [DW-1:0] ez, input logic [2*DW-1:0] ex);
        logic [15:0] dc;
        dc = 16'(done_cyc);
        exp_q.push_back({dc, ez, ex});
    endtask

    // driver: one Start pulse with hand-computed expected results
    task automatic run(input logic [DW-1:0] va, input logic [DW-1:0] vb, input logic [DW-1:0] vc,
                       input logic [DW-1:0] ez, input logic [2*DW-1:0] ex);
        @(negedge Clk);
        push_exp(cyc + 6, ez, ex);
        a = va; b = vb; c = vc; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        a = ~va; b = ~vb; c = ~vc;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge Clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            n_vec = n_vec + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s_timeout: got %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge Clk);
    endtask

    // held-Start table: operands change every cycle; only k%6==0 entries are latched
    logic [DW-1:0] hold_a [18];
    logic [DW-1:0] hold_b [18];
    logic [DW-1:0] hold_c [18];

    initial begin
        cyc = 0; n_vec = 0; n_fail = 0;
        Rst = 1'b1; Start = 1'b0; a = '0; b = '0; c = '0;
        for (int k = 0; k < 18; k++) begin
            hold_a[k] = 8'(99 + k);
            hold_b[k] = 8'(17 * k + 1);
            hold_c[k] = 8'(200 - k);
        end
        hold_a[0]  = 8'd3;   hold_b[0]  = 8'd4;   hold_c[0]  = 8'd7;
        hold_a[6]  = 8'd50;  hold_b[6]  = 8'd60;  hold_c[6]  = 8'd2;
        hold_a[12] = 8'd128; hold_b[12] = 8'd128; hold_c[12] = 8'd255;

        repeat (3) @(negedge Clk);
        check("reset_done", 32'(Done), 0);
        check("reset_z", 32'(z), 0);
        check("reset_x", 32'(x), 0);
        check("reset_state", 32'(dbg_state), 32'(S_WAIT));
        Rst = 1'b0;
        repeat (2) @(negedge Clk);

        run(8'd10,  8'd20,  8'd5,   8'd15,  16'd20);    drain("v1");
        check("hold_z", 32'(z), 15);
        check("hold_x", 32'(x), 20);
        run(8'd200, 8'd100, 8'd3,   8'd44,  16'd556);   drain("v2");
        run(8'd1,   8'd5,   8'd0,   8'd1,   16'd65530); drain("v3");
        run(8'd255, 8'd255, 8'd255, 8'd254, 16'd64771); drain("v4");

        // Start held high across three back-to-back runs
        @(negedge Clk);
        push_exp(cyc + 6,  8'd7,  16'd14);
        push_exp(cyc + 12, 8'd52, 16'd65526);
        push_exp(cyc + 18, 8'd0,  16'd32640);
        Start = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (k != 0) @(negedge Clk);
            a = hold_a[k]; b = hold_b[k]; c = hold_c[k];
        end
        @(negedge Clk);
        Start = 1'b0;
        drain("held");

        // abort in S_MUL, then a normal run
        run(8'd1, 8'd2, 8'd3, 8'd0, 16'd0);
        void'(exp_q.pop_back());
        begin
            int k;
            k = 0;
            while (dbg_state != S_MUL && k < 10) begin
                @(negedge Clk);
                k++;
            end
        end
        check("reached_mul", 32'(dbg_state), 32'(S_MUL));
        Rst = 1'b1;
        #1;
        check("abort_z", 32'(z), 0);
        check("abort_x", 32'(x), 0);
        check("abort_done", 32'(Done), 0);
        check("abort_state", 32'(dbg_state), 32'(S_WAIT));
        @(negedge Clk);
        Rst = 1'b0;
        repeat (8) @(negedge Clk);
        run(8'd10, 8'd20, 8'd5, 8'd15, 16'd20); drain("after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
